spi_bus_arb: RTL
================

SPI_BUS_ARB -- requirements
Module: spi_bus_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, fixed number of requesters (legal range 2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the maximum number of clk cycles to wait for bus_ack (legal range 16..1023).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset_l, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req_addr, input, 7*NREQ bits, register address per requester; requester i uses bits [7i+6:7i].
REQ-006 The block SHALL have port req_wr_data, input, 8*NREQ bits, write data per requester; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have ports req_re and req_we, inputs, NREQ bits each, level read/write requests held until the matching req_ack.
REQ-008 The block SHALL have port req_ack, output, NREQ bits, a one-cycle completion pulse to the served requester.
REQ-009 The block SHALL have port req_rd_data, output, 8 bits, read data valid only in the req_ack cycle, 0 otherwise.
REQ-010 The block SHALL have port req_err, output, 1 bit, a timeout flag valid only in the req_ack cycle.
REQ-011 The block SHALL have ports bus_addr (output, 7 bits) and bus_wr_data (output, 8 bits), which drive the SPI master bus.
REQ-012 The block SHALL have ports bus_re and bus_we (outputs, 1 bit each) driving the SPI master, plus bus_rd_data (input, 8 bits) and bus_ack (input, 1 bit) returning from it.
REQ-013 The block SHALL have port grant, output, 2 bits, the index of the requester currently owning the bus.
REQ-014 The block SHALL have port busy, output, 1 bit, high while in any state other than IDLE.

Function
REQ-015 The block SHALL implement state machine states IDLE, ISSUE, WAIT_ACK and DONE.
REQ-016 In IDLE, when any bit of (req_re|req_we) is set, the block SHALL select the requester by round-robin: the first requesting index strictly after last_grant, wrapping modulo NREQ.
REQ-017 On selection the block SHALL latch the requester's addr, wr_data and operation into bus_addr, bus_wr_data and an op register, load grant, and go to ISSUE.
REQ-018 If a requester asserts both req_we and req_re, the block SHALL perform the write; the read stays pending and is served in a later arbitration.
REQ-019 In ISSUE the block SHALL pulse bus_we or bus_re for exactly one cycle, clear the timeout counter, and go to WAIT_ACK.
REQ-020 bus_addr and bus_wr_data SHALL remain stable from ISSUE through DONE; request inputs SHALL NOT be resampled during a transaction.
REQ-021 In WAIT_ACK, on bus_ack the block SHALL capture bus_rd_data (reads) or 0 (writes) and go to DONE with err=0.
REQ-022 In WAIT_ACK, the 10-bit counter SHALL increment every cycle; when it equals TIMEOUT without bus_ack, the block SHALL go to DONE with err=1 and capture data 8'hFF.
REQ-023 bus_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (err=0).
REQ-024 A bus_ack arriving in IDLE, ISSUE or DONE SHALL be ignored.
REQ-025 In DONE the block SHALL pulse req_ack[grant] for one cycle, drive req_rd_data and req_err, update last_grant to grant, and return to IDLE.
REQ-026 Minimum spacing between bus_re/bus_we pulses SHALL be 4 cycles (IDLE, ISSUE, at least one WAIT_ACK cycle, DONE); the block adds 3 cycles of latency beyond the master's ack delay.
REQ-027 A requester that drops its request mid-transaction SHALL still receive req_ack; the transaction SHALL NOT be aborted.

Reset
REQ-028 Asserting reset_l low SHALL immediately set: state IDLE; bus_re, bus_we, req_ack, req_err and busy to 0; bus_addr, bus_wr_data, req_rd_data and grant to 0; counter 0; last_grant NREQ-1, so requester 0 is served first.
REQ-029 A reset in the middle of a transaction SHALL discard that transaction with no req_ack; a late bus_ack after release SHALL be ignored per REQ-024.

Verification
REQ-030 Scenario: single read by req 1 at addr 7'h14, master returns 8'hA5 -> exactly one bus_re pulse with bus_addr=7'h14; req_ack=3'b010 with req_rd_data=8'hA5 and req_err=0.
REQ-031 Scenario: all three request writes simultaneously after reset -> service order 0,1,2; exactly three bus_we pulses, each with the matching address and data.
REQ-032 Scenario: req 2 requests continuously while req 0 requests once -> after req 2 is served, req 0 is served next (no starvation).
REQ-033 Scenario: master never acks, TIMEOUT=16 -> req_ack 17 cycles after the bus_re pulse, with req_rd_data=8'hFF and req_err=1.
REQ-034 Scenario: req 0 asserts both re and we -> a write is issued first, then the read is served in a separate transaction.
REQ-035 Scenario: reset_l pulsed low during WAIT_ACK, then a stray bus_ack -> no req_ack is generated; the next request is served normally.

Source files
------------

// File: rtl/spi_bus_arb.sv
// Round-robin arbiter that shares one SPI master register bus among NREQ requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT_ACK -> DONE and is bounded by a TIMEOUT watchdog.
module spi_bus_arb #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wr_data,
  input  logic [NREQ-1:0]   req_re,
  input  logic [NREQ-1:0]   req_we,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        req_rd_data,
  output logic              req_err,
  output logic [6:0]        bus_addr,
  output logic [7:0]        bus_wr_data,
  output logic              bus_re,
  output logic              bus_we,
  input  logic [7:0]        bus_rd_data,
  input  logic              bus_ack,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StDone} state_e;

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);
  localparam logic [1:0] LastIdx    = 2'(NREQ - 1);

  state_e     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       op_we_q, op_we_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  logic [3:0] pend_ext;
  logic [1:0] cand;
  logic       sel_vld;
  logic [1:0] sel_idx;
  logic [6:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       sel_we;

  // Round-robin pick: scan from farthest to nearest after last_q so the nearest requester wins.
  always_comb begin
    pend_ext             = '0;
    pend_ext[NREQ-1:0]   = req_re | req_we;
    sel_vld              = 1'b0;
    sel_idx              = '0;
    cand                 = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = 2'((int'(last_q) + k) % int'(NREQ));
      if (pend_ext[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (sel_idx == 2'(i)) begin
        sel_addr  = req_addr[7*i +: 7];
        sel_wdata = req_wr_data[8*i +: 8];
        sel_we    = req_we[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_we_d = op_we_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (sel_vld) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // A simultaneous read stays pending on req_re and wins a later arbitration.
          op_we_d = sel_we;
          grant_d = sel_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        cnt_d = cnt_q + 10'd1;
        if (bus_ack) begin
          rdata_d = op_we_q ? 8'h00 : bus_rd_data;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_d == TimeoutCnt) begin
          rdata_d = 8'hFF;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      op_we_q <= 1'b0;
      grant_q <= '0;
      last_q  <= LastIdx;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_we_q <= op_we_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus_addr    = addr_q;
    bus_wr_data = wdata_q;
    bus_re      = (state_q == StIssue) && !op_we_q;
    bus_we      = (state_q == StIssue) && op_we_q;
    grant       = grant_q;
    busy        = (state_q != StIdle);
    req_ack     = (state_q == StDone) ? (NREQ'(1) << grant_q) : '0;
    req_rd_data = (state_q == StDone) ? rdata_q : 8'h00;
    req_err     = (state_q == StDone) && err_q;
  end

endmodule
